conversor_bcd: RTL and testbench
================================

CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port entradaBin, input, 32 bits: unsigned binary operand, sampled only when a start is accepted.
REQ-004 SHALL have port start, input, 1 bit: conversion request, level-sampled each rising edge.
REQ-005 SHALL have port digitoSel, input, 4 bits: decimal digit index, 0 = units through 9 = 10^9.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse on result update.
REQ-008 SHALL have port bcd, output, 40 bits: registered result, 10 nibbles, nibble k = digit k.
REQ-009 SHALL have port digitoOut, output, 32 bits: selected digit, zero-extended; feeds the 7-segment decoder input directly.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-011 In IDLE with start=1, SHALL load entradaBin into a 32-bit shift register, clear the 40-bit working BCD register and the 5-bit iteration counter, and enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL add 3 to every working BCD nibble >= 5, then shift {BCD, binary} left by one bit as a 72-bit value, then increment the counter (shift-add-3).
REQ-013 On the 32nd SHIFT cycle, SHALL copy the final working BCD into bcd, assert done for exactly the next cycle, and return to IDLE.
REQ-014 Latency SHALL be fixed: done is high in the cycle following the 32nd rising edge after the start-accepting edge, for every operand value.
REQ-015 busy SHALL equal (state == SHIFT): high on the start-accepting edge through the completing edge, low otherwise.
REQ-016 start SHALL be ignored while busy=1; no queuing, and the operand is not re-sampled.
REQ-017 start=1 in the done cycle SHALL be accepted, giving back-to-back conversions with one IDLE cycle between them.
REQ-018 bcd SHALL hold its previous value for the whole conversion and change only on the completing edge.
REQ-019 digitoOut SHALL be combinational from bcd and digitoSel: {28'b0, bcd[4k+3:4k]} for k = digitoSel.
REQ-020 digitoSel 10..15 SHALL yield digitoOut = 32'd15, so the downstream decoder blanks.
REQ-021 No overflow is possible: the maximum operand 4294967295 fits in 10 digits, and no error output exists.

Reset
REQ-022 rst_n low SHALL immediately force state = IDLE, counter = 0, shift and working registers = 0, bcd = 0, busy = 0 and done = 0.
REQ-023 Reset during SHIFT SHALL abort the conversion; no done pulse follows and bcd reads 0.
REQ-024 After release, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 Macro CONVERSOR_BCD_BLANK_ZEROS_EN SHALL control leading-zero blanking.
REQ-026 With the macro defined, digitoOut SHALL be 32'd15 for any digit index above the most-significant nonzero digit of bcd; digit 0 is never blanked, so value 0 shows "0".
REQ-027 With the macro undefined, digitoOut SHALL follow REQ-019 and REQ-020 only, so leading zeros display as 0.
REQ-028 bcd, busy, done and all timing SHALL be identical with and without the macro.

Verification
REQ-029 Reset, then start with entradaBin=0 -> done after 32 cycles; bcd=40'h0; digitoOut=0 for digitoSel 0.
REQ-030 entradaBin=32'hFFFFFFFF -> bcd=40'h4294967295; digitoSel 9 gives 4 and digitoSel 0 gives 5.
REQ-031 entradaBin=1234, then start pulses at cycles 5 and 20 of the conversion -> single done at cycle 32; bcd=40'h0000001234; operand not re-sampled.
REQ-032 Back-to-back: start held high with operands 9 then 10 -> two done pulses, 33 cycles apart; bcd=...09 then ...10.
REQ-033 rst_n low at cycle 16 of converting 5678 -> busy=0, done never pulses, bcd=0.
REQ-034 bcd=...1234, digitoSel=4 -> digitoOut=15 with the macro, 0 without; digitoSel=3 -> 1 in both builds.

Source files
------------

// File: rtl/conversor_bcd_if.sv
// Handshake and result bundle for conversor_bcd; the master drives the operand,
// start and digit select, and the slave returns busy/done, the BCD word and the selected digit.
interface conversor_bcd_if;
  logic [31:0] entradaBin;
  logic        start;
  logic [3:0]  digitoSel;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic [31:0] digitoOut;

  modport master (
    output entradaBin, start, digitoSel,
    input  busy, done, bcd, digitoOut
  );

  modport slave (
    input  entradaBin, start, digitoSel,
    output busy, done, bcd, digitoOut
  );
endinterface

// File: rtl/conversor_bcd.sv
// 32-bit binary to 10-digit BCD converter (shift-add-3, fixed 32-cycle latency).
// Define CONVERSOR_BCD_BLANK_ZEROS_EN to blank leading zeros on digitoOut.
module conversor_bcd (
  input  logic            clk,
  input  logic            rst_n,
  conversor_bcd_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] work_q, work_d;
  logic [39:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  logic [39:0] adj;
  logic [71:0] shifted;
  logic [3:0]  sel_nib;
`ifdef CONVERSOR_BCD_BLANK_ZEROS_EN
  logic [3:0]  msd;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;

    // Correct each nibble before the shift so it carries properly into the next digit
    adj = '0;
    for (int k = 0; k < 10; k++) begin
      adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ? work_q[4*k +: 4] + 4'd3
                                                 : work_q[4*k +: 4];
    end
    shifted = {adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          bin_d   = bus.entradaBin;
          work_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        work_d = shifted[71:32];
        bin_d  = shifted[31:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          bcd_d   = shifted[71:32];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Digit select; out-of-range indices return 15 so the 7-segment decoder blanks
  always_comb begin
    sel_nib = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (bus.digitoSel == 4'(k)) sel_nib = bcd_q[4*k +: 4];
    end
`ifdef CONVERSOR_BCD_BLANK_ZEROS_EN
    msd = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) msd = 4'(k);
    end
    if (bus.digitoSel > msd) sel_nib = 4'hF;
`endif
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.digitoOut = {28'b0, sel_nib};

endmodule

// File: tb/tb_conversor_bcd.sv
// Randomized self-checking bench for conversor_bcd against a decimal-arithmetic reference model.
module tb_conversor_bcd;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  longint unsigned last_val;

  conversor_bcd_if bus();

  conversor_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] to_bcd(input longint unsigned v);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_digit(input longint unsigned v, input int sel);
    longint unsigned p;
    p = 1;
    if (sel > 9) return 64'd15;
    for (int i = 0; i < sel; i++) p = p * 10;
`ifdef CONVERSOR_BCD_BLANK_ZEROS_EN
    if (sel > 0 && v < p) return 64'd15;
`endif
    return (v / p) % 10;
  endfunction

  task automatic check_digits(input longint unsigned v);
    for (int sel = 0; sel < 16; sel++) begin
      bus.digitoSel = 4'(sel);
      #1;
      check($sformatf("digit%0d", sel), {32'b0, bus.digitoOut}, exp_digit(v, sel));
    end
  endtask

  // One conversion; optionally pulses start mid-conversion with a different operand
  task automatic do_conv(input logic [31:0] v, input bit pulse_mid);
    int n;
    bit got;
    @(negedge clk);
    bus.entradaBin = v;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    check("busy_on_accept", {63'b0, bus.busy}, 64'd1);
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      bus.start      = pulse_mid && (n == 4 || n == 19);
      bus.entradaBin = $urandom;
      @(posedge clk); #1;
      n++;
      if (n == 16) check("bcd_hold", {24'b0, bus.bcd}, {24'b0, to_bcd(last_val)});
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    check("latency", 64'(n), 64'd32);
    check("bcd", {24'b0, bus.bcd}, {24'b0, to_bcd(longint'(v))});
    last_val = longint'(v);
    @(posedge clk); #1;
    check("done_pulse_len", {63'b0, bus.done}, 64'd0);
    check("busy_idle", {63'b0, bus.busy}, 64'd0);
    check_digits(last_val);
  endtask

  initial begin
    int n, t1, t2;
    bit seen;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.entradaBin = '0;
    bus.digitoSel  = '0;
    last_val       = 0;
    #12;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_bcd", {24'b0, bus.bcd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_conv(32'd0, 1'b0);
    do_conv(32'hFFFF_FFFF, 1'b0);
    do_conv(32'd1234, 1'b1);
    for (int i = 0; i < 8; i++) do_conv($urandom >> $urandom_range(0, 31), 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.entradaBin = 32'd9;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.entradaBin = 32'd10;
    n  = 0;
    t1 = 0;
    t2 = 0;
    while (n < 80 && t2 == 0) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        if (t1 == 0) begin
          t1 = n;
          check("b2b_bcd1", {24'b0, bus.bcd}, {24'b0, to_bcd(9)});
        end else begin
          t2 = n;
          check("b2b_bcd2", {24'b0, bus.bcd}, {24'b0, to_bcd(10)});
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_first", 64'(t1), 64'd32);
    check("b2b_gap", 64'(t2 - t1), 64'd33);
    last_val = 10;
    repeat (2) @(posedge clk);
    #1;
    check_digits(last_val);

    // Reset in the middle of a conversion
    @(negedge clk);
    bus.entradaBin = 32'd5678;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_done", {63'b0, bus.done}, 64'd0);
    check("abort_bcd", {24'b0, bus.bcd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", {63'b0, seen}, 64'd0);
    check("abort_bcd_after", {24'b0, bus.bcd}, 64'd0);
    last_val = 0;
    check_digits(last_val);

    do_conv($urandom, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
